// File: rtl/rst_seq.sv
// Reset sequencer: releases peripheral reset, then core reset, after PLL lock;
// tears down core-first on a filtered reboot request and latches poweroff.
module rst_seq #(
    parameter int PERIPH_DELAY  = 16,
    parameter int CORE_DELAY    = 16,
    parameter int DRAIN_CYCLES  = 8,
    parameter int HOLD_CYCLES   = 32,
    parameter int FILTER_CYCLES = 4,
    parameter int CNT_WIDTH     = 16
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       pll_locked,
    input  logic       reboot_n,
    input  logic       poweroff,
    output logic       periph_resetn,
    output logic       core_resetn,
    output logic       powered_off,
    output logic [7:0] reboot_count,
    output logic [2:0] state_o
);

    localparam int FW = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;

    typedef enum logic [2:0] {
        WAIT_LOCK     = 3'd0,
        REL_PERIPH    = 3'd1,
        REL_CORE      = 3'd2,
        RUN           = 3'd3,
        ASSERT_CORE   = 3'd4,
        ASSERT_PERIPH = 3'd5,
        OFF           = 3'd6
    } state_t;

    state_t               state, state_n;
    logic [CNT_WIDTH-1:0] cnt, cnt_n;
    logic [FW-1:0]        filt_cnt, filt_cnt_n;
    logic                 lock_meta, lock_s;
    logic                 periph_n, core_n, off_n;
    logic [7:0]           count_n;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state         <= WAIT_LOCK;
            cnt           <= '0;
            filt_cnt      <= '0;
            lock_meta     <= 1'b0;
            lock_s        <= 1'b0;
            periph_resetn <= 1'b0;
            core_resetn   <= 1'b0;
            powered_off   <= 1'b0;
            reboot_count  <= 8'd0;
        end else begin
            state         <= state_n;
            cnt           <= cnt_n;
            filt_cnt      <= filt_cnt_n;
            lock_meta     <= pll_locked;
            lock_s        <= lock_meta;
            periph_resetn <= periph_n;
            core_resetn   <= core_n;
            powered_off   <= off_n;
            reboot_count  <= count_n;
        end
    end

    // Priority: terminal OFF, then poweroff, then lock loss, then per-state sequencing.
    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        filt_cnt_n = '0;
        periph_n   = periph_resetn;
        core_n     = core_resetn;
        off_n      = powered_off;
        count_n    = reboot_count;

        if (state == OFF || poweroff) begin
            state_n  = OFF;
            periph_n = 1'b0;
            core_n   = 1'b0;
            off_n    = 1'b1;
            cnt_n    = '0;
        end else if (!lock_s && state != WAIT_LOCK) begin
            state_n  = WAIT_LOCK;
            periph_n = 1'b0;
            core_n   = 1'b0;
            cnt_n    = '0;
        end else begin
            case (state)
                WAIT_LOCK: begin
                    periph_n = 1'b0;
                    core_n   = 1'b0;
                    if (lock_s) begin
                        state_n = REL_PERIPH;
                        cnt_n   = '0;
                    end
                end
                REL_PERIPH: begin
                    if (cnt == CNT_WIDTH'(PERIPH_DELAY - 1)) begin
                        state_n  = REL_CORE;
                        periph_n = 1'b1;
                        cnt_n    = '0;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
                REL_CORE: begin
                    if (cnt == CNT_WIDTH'(CORE_DELAY - 1)) begin
                        state_n = RUN;
                        core_n  = 1'b1;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
                RUN: begin
                    if (!reboot_n) begin
                        if (filt_cnt == FW'(FILTER_CYCLES - 1)) begin
                            state_n = ASSERT_CORE;
                            core_n  = 1'b0;
                            cnt_n   = '0;
                            count_n = (reboot_count == 8'hFF) ? reboot_count : reboot_count + 8'd1;
                        end else begin
                            filt_cnt_n = filt_cnt + 1'b1;
                        end
                    end
                end
                ASSERT_CORE: begin
                    if (cnt == CNT_WIDTH'(DRAIN_CYCLES - 1)) begin
                        state_n  = ASSERT_PERIPH;
                        periph_n = 1'b0;
                        cnt_n    = '0;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
                ASSERT_PERIPH: begin
                    if (cnt == CNT_WIDTH'(HOLD_CYCLES - 1)) begin
                        state_n = WAIT_LOCK;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
                default: begin
                    state_n  = WAIT_LOCK;
                    periph_n = 1'b0;
                    core_n   = 1'b0;
                    cnt_n    = '0;
                end
            endcase
        end
    end

    assign state_o = state;

endmodule

// File: tb/tb_rst_seq.sv
// Scoreboard bench for rst_seq: stimulus queues expected output changes with the
// edge number they must occur on; a negedge monitor compares each observed change.
module tb_rst_seq;

    logic       clk = 1'b0;
    logic       resetn, pll_locked, reboot_n, poweroff;
    logic       periph_resetn, core_resetn, powered_off;
    logic [7:0] reboot_count;
    logic [2:0] state_o;

    typedef struct {
        int         cyc;
        logic [2:0] st;
        logic       p;
        logic       c;
        logic       off;
        logic [7:0] cnt;
    } exp_t;

    exp_t        q[$];
    int          cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    bit          mon_en = 1'b0;
    bit          mon_init = 1'b0;
    logic [13:0] cur, prev;

    rst_seq dut (
        .clk          (clk),
        .resetn       (resetn),
        .pll_locked   (pll_locked),
        .reboot_n     (reboot_n),
        .poweroff     (poweroff),
        .periph_resetn(periph_resetn),
        .core_resetn  (core_resetn),
        .powered_off  (powered_off),
        .reboot_count (reboot_count),
        .state_o      (state_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic waitUntil(input int c);
        while (cyc < c) step();
    endtask

    task automatic applyStimulus(input logic rstn, input logic pll, input logic rb_n, input logic po);
        resetn     = rstn;
        pll_locked = pll;
        reboot_n   = rb_n;
        poweroff   = po;
    endtask

    task automatic expectAt(input int c, input logic [2:0] st, input logic p, input logic cr,
                            input logic off, input logic [7:0] cnt);
        exp_t e;
        e.cyc = c;
        e.st  = st;
        e.p   = p;
        e.c   = cr;
        e.off = off;
        e.cnt = cnt;
        q.push_back(e);
    endtask

    // Four-cycle reboot request issued from RUN, followed by the full re-release.
    task automatic doReboot(input logic [7:0] cnt);
        int k;
        k = cyc;
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        expectAt(k + 4,  3'd4, 1'b1, 1'b0, 1'b0, cnt);
        expectAt(k + 12, 3'd5, 1'b0, 1'b0, 1'b0, cnt);
        expectAt(k + 44, 3'd0, 1'b0, 1'b0, 1'b0, cnt);
        expectAt(k + 45, 3'd1, 1'b0, 1'b0, 1'b0, cnt);
        expectAt(k + 61, 3'd2, 1'b1, 1'b0, 1'b0, cnt);
        expectAt(k + 77, 3'd3, 1'b1, 1'b1, 1'b0, cnt);
        waitUntil(k + 4);
        reboot_n = 1'b1;
        waitUntil(k + 78);
    endtask

    // Monitor: every change of the observed output tuple consumes one expected entry.
    always @(negedge clk) begin
        if (mon_en) begin
            exp_t e;
            cur = {state_o, periph_resetn, core_resetn, powered_off, reboot_count};
            checkOutput("core_implies_periph", 32'(!core_resetn || periph_resetn), 32'd1);
            if (!mon_init) begin
                prev     = cur;
                mon_init = 1'b1;
            end else if (cur !== prev) begin
                if (q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("[TB] FAIL unexpected_change at cycle %0d: got 0x%0h, expected no change from 0x%0h",
                             cyc, cur, prev);
                end else begin
                    e = q.pop_front();
                    checkOutput("outputs", 32'(cur), 32'({e.st, e.p, e.c, e.off, e.cnt}));
                    checkOutput("change_cycle", cyc, e.cyc);
                end
                prev = cur;
            end
        end
    end

    initial begin
        int k;
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
        waitUntil(3);
        checkOutput("reset_state", 32'(state_o), 32'd0);
        checkOutput("reset_periph", 32'(periph_resetn), 32'd0);
        checkOutput("reset_core", 32'(core_resetn), 32'd0);
        checkOutput("reset_off", 32'(powered_off), 32'd0);
        checkOutput("reset_count", 32'(reboot_count), 32'd0);
        mon_en = 1'b1;

        // Power-on sequence with lock present from the start.
        resetn = 1'b1;
        expectAt(6,  3'd1, 1'b0, 1'b0, 1'b0, 8'd0);
        expectAt(22, 3'd2, 1'b1, 1'b0, 1'b0, 8'd0);
        expectAt(38, 3'd3, 1'b1, 1'b1, 1'b0, 8'd0);

        // Three-cycle reboot glitch must be filtered out.
        waitUntil(40);
        reboot_n = 1'b0;
        waitUntil(43);
        reboot_n = 1'b1;
        waitUntil(46);
        doReboot(8'd1);

        // Lock lost for three cycles in RUN.
        waitUntil(125);
        pll_locked = 1'b0;
        expectAt(128, 3'd0, 1'b0, 1'b0, 1'b0, 8'd1);
        expectAt(131, 3'd1, 1'b0, 1'b0, 1'b0, 8'd1);
        expectAt(147, 3'd2, 1'b1, 1'b0, 1'b0, 8'd1);
        expectAt(163, 3'd3, 1'b1, 1'b1, 1'b0, 8'd1);
        waitUntil(128);
        pll_locked = 1'b1;

        // Poweroff on the edge the reboot filter completes: OFF wins, count unchanged.
        waitUntil(170);
        reboot_n = 1'b0;
        waitUntil(173);
        poweroff = 1'b1;
        expectAt(174, 3'd6, 1'b0, 1'b0, 1'b1, 8'd1);
        waitUntil(174);
        poweroff = 1'b0;
        for (int i = 0; i < 15; i++) begin
            step();
            pll_locked = ~pll_locked;
        end
        waitUntil(190);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
        expectAt(191, 3'd0, 1'b0, 1'b0, 1'b0, 8'd0);
        waitUntil(191);
        resetn = 1'b1;
        expectAt(194, 3'd1, 1'b0, 1'b0, 1'b0, 8'd0);
        expectAt(210, 3'd2, 1'b1, 1'b0, 1'b0, 8'd0);

        // One-cycle poweroff during REL_CORE, then OFF must ignore lock and reboot.
        waitUntil(215);
        poweroff = 1'b1;
        expectAt(216, 3'd6, 1'b0, 1'b0, 1'b1, 8'd0);
        waitUntil(216);
        poweroff = 1'b0;
        reboot_n = 1'b0;
        while (cyc < 229) begin
            step();
            pll_locked = ~pll_locked;
        end
        waitUntil(230);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
        expectAt(231, 3'd0, 1'b0, 1'b0, 1'b0, 8'd0);
        waitUntil(231);
        resetn = 1'b1;
        expectAt(234, 3'd1, 1'b0, 1'b0, 1'b0, 8'd0);
        expectAt(250, 3'd2, 1'b1, 1'b0, 1'b0, 8'd0);
        expectAt(266, 3'd3, 1'b1, 1'b1, 1'b0, 8'd0);
        waitUntil(268);

        // Saturation of the reboot counter.
        for (int i = 1; i <= 256; i++) begin
            doReboot((i > 255) ? 8'd255 : 8'(i));
        end

        // Reset in the middle of ASSERT_CORE.
        k = cyc;
        reboot_n = 1'b0;
        expectAt(k + 4, 3'd4, 1'b1, 1'b0, 1'b0, 8'd255);
        waitUntil(k + 4);
        reboot_n = 1'b1;
        waitUntil(k + 6);
        resetn = 1'b0;
        expectAt(k + 7, 3'd0, 1'b0, 1'b0, 1'b0, 8'd0);
        waitUntil(k + 7);
        resetn = 1'b1;
        expectAt(k + 10, 3'd1, 1'b0, 1'b0, 1'b0, 8'd0);
        waitUntil(k + 14);

        checkOutput("queue_drained", 32'(q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
